// File: rtl/hazard_ctrl_mc_if.sv
// rtl/hazard_ctrl_mc_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs1D, rs2D;
    logic [REG_AW-1:0] rs1E, rs2E, rdE;
    logic [REG_AW-1:0] rdM, rdW;
    logic              resultSrcE, PCSrcE, mcStartE;
    logic              regWriteM, regWriteW;
    logic              memReqM, memReadyM;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, flushM, flushW;
    logic [1:0]        fwdAE, fwdBE;
    logic              busy, memTimeout;
    logic [CNT_W-1:0]  stallCycles;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
               resultSrcE, PCSrcE, mcStartE, regWriteM, regWriteW,
               memReqM, memReadyM,
        input  stallF, stallD, stallE, stallM,
               flushD, flushE, flushM, flushW,
               fwdAE, fwdBE, busy, memTimeout, stallCycles
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
               resultSrcE, PCSrcE, mcStartE, regWriteM, regWriteW,
               memReqM, memReadyM,
        output stallF, stallD, stallE, stallM,
               flushD, flushE, flushM, flushW,
               fwdAE, fwdBE, busy, memTimeout, stallCycles
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - 5-stage hazard controller: forwarding, load-use, multi-cycle ops, memory waits
// Optional memory-wait logic enabled by defining HAZARD_MEM_WAIT_EN.
module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int MEM_TO = 255,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_mc_if.slave  hz
);
    localparam int MCW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    typedef enum logic [1:0] {RUN, MC_BUSY, MEM_WAIT} state_t;

    state_t           state;
    logic [MCW-1:0]   mc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_wait, lw_haz, mc_start, mc_hold, mc_stall;
    logic             stall_f, stall_e;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m, input logic we_m,
        input logic [REG_AW-1:0] rd_w, input logic we_w
    );
        if (we_m && rd_m != '0 && rs == rd_m)      return 2'b10;
        else if (we_w && rd_w != '0 && rs == rd_w) return 2'b01;
        else                                       return 2'b00;
    endfunction

`ifdef HAZARD_MEM_WAIT_EN
    localparam int WW = $clog2(MEM_TO + 1);
    logic [WW-1:0] wait_cnt;
    logic          mem_timeout;

    assign mem_wait = hz.memReqM && !hz.memReadyM;

    // Counter saturates at MEM_TO so a very long wait cannot wrap it back below the threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != WW'(MEM_TO)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WW'(MEM_TO - 1)) mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign hz.memTimeout = mem_timeout;
    assign hz.stallM     = rst_n && mem_wait;
    assign hz.flushW     = !rst_n || mem_wait;
`else
    logic unused_mem;
    assign unused_mem    = hz.memReqM ^ hz.memReadyM;
    assign mem_wait      = 1'b0;
    assign hz.memTimeout = 1'b0;
    assign hz.stallM     = 1'b0;
    assign hz.flushW     = 1'b0;
`endif

    assign lw_haz   = hz.resultSrcE && hz.rdE != '0 && (hz.rs1D == hz.rdE || hz.rs2D == hz.rdE);
    assign mc_start = (state != MC_BUSY) && hz.mcStartE && !mem_wait;
    assign mc_hold  = (state == MC_BUSY) && (mc_cnt != '0 || mem_wait);
    assign mc_stall = mc_start || mc_hold;

    assign stall_f = rst_n && (mem_wait || mc_stall || lw_haz);
    assign stall_e = rst_n && (mem_wait || mc_stall);

    assign hz.stallF = stall_f;
    assign hz.stallD = stall_f;
    assign hz.stallE = stall_e;
    // A held E stage (memory wait or multi-cycle op) must never also be flushed.
    assign hz.flushD = !rst_n || (hz.PCSrcE && !mem_wait && !mc_stall);
    assign hz.flushE = !rst_n || ((hz.PCSrcE || lw_haz) && !mem_wait && !mc_stall);
    assign hz.flushM = !rst_n || mc_stall;

    assign hz.fwdAE = rst_n ? fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW) : 2'b00;
    assign hz.fwdBE = rst_n ? fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW) : 2'b00;

    assign hz.busy        = (state != RUN);
    assign hz.stallCycles = stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            mc_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            case (state)
                MC_BUSY: begin
                    if (mc_cnt != '0) mc_cnt <= mc_cnt - 1'b1;
                    if (mc_cnt == '0 && !mem_wait) state <= RUN;
                end
                // The release cycle of MEM_WAIT behaves like RUN so an op held in E can start.
                default: begin
                    if (mem_wait) begin
                        state <= MEM_WAIT;
                    end else if (hz.mcStartE) begin
                        state  <= MC_BUSY;
                        mc_cnt <= MCW'(MC_LAT - 2);
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb/tb_hazard_ctrl_mc.sv - directed and randomized checks of hazard_ctrl_mc against a behavioural model
module tb_hazard_ctrl_mc;
    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int MEM_TO = 2;
    localparam int CNT_W  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif();

    hazard_ctrl_mc #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .MEM_TO(MEM_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hif)
    );

    int total = 0;
    int bad   = 0;

    // Model: the op in E counts its age upward; memory waits are tracked as a run length.
    bit m_mc_active, m_mem_busy, m_timeout;
    int m_age, m_wait_run, m_stalls;
    bit mw, lw, mc_hold;
    bit e_stallF, e_stallD, e_stallE, e_stallM, e_flushD, e_flushE, e_flushM, e_flushW, e_busy;
    logic [1:0] e_fwdA, e_fwdB;

`ifdef HAZARD_MEM_WAIT_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [1:0] fwd_of(logic [REG_AW-1:0] rs);
        if (hif.regWriteM && hif.rdM != 0 && rs == hif.rdM) return 2'b10;
        if (hif.regWriteW && hif.rdW != 0 && rs == hif.rdW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        mw = MEM_EN && hif.memReqM && !hif.memReadyM;
        lw = hif.resultSrcE && hif.rdE != 0 && (hif.rs1D == hif.rdE || hif.rs2D == hif.rdE);
        if (m_mc_active) mc_hold = (m_age < MC_LAT - 1) || mw;
        else             mc_hold = hif.mcStartE && !mw;
        if (!rst_n) begin
            {e_stallF, e_stallD, e_stallE, e_stallM} = 4'b0000;
            {e_flushD, e_flushE, e_flushM} = 3'b111;
            e_flushW = MEM_EN;
            e_fwdA = 2'b00;
            e_fwdB = 2'b00;
        end else begin
            e_stallF = mw || mc_hold || lw;
            e_stallD = e_stallF;
            e_stallE = mw || mc_hold;
            e_stallM = mw;
            e_flushD = !mw && !mc_hold && hif.PCSrcE;
            e_flushE = !mw && !mc_hold && (hif.PCSrcE || lw);
            e_flushM = mc_hold;
            e_flushW = mw;
            e_fwdA = fwd_of(hif.rs1E);
            e_fwdB = fwd_of(hif.rs2E);
        end
        e_busy = m_mc_active || m_mem_busy;
    endtask

    task automatic model_tick();
        bit was_active;
        was_active = m_mc_active;
        if (!rst_n) begin
            m_mc_active = 0; m_mem_busy = 0; m_timeout = 0;
            m_age = 0; m_wait_run = 0; m_stalls = 0;
        end else begin
            if (e_stallF && m_stalls < (1 << CNT_W) - 1) m_stalls++;
            if (mw) begin
                m_wait_run++;
                if (m_wait_run >= MEM_TO) m_timeout = 1;
            end else begin
                m_wait_run = 0;
            end
            if (was_active) begin
                if (m_age >= MC_LAT - 1 && !mw) m_mc_active = 0;
                else m_age++;
            end else if (hif.mcStartE && !mw) begin
                m_mc_active = 1;
                m_age = 1;
            end
            m_mem_busy = !was_active && mw;
        end
    endtask

    task automatic compare_all();
        chk("stallF", hif.stallF, e_stallF);
        chk("stallD", hif.stallD, e_stallD);
        chk("stallE", hif.stallE, e_stallE);
        chk("stallM", hif.stallM, e_stallM);
        chk("flushD", hif.flushD, e_flushD);
        chk("flushE", hif.flushE, e_flushE);
        chk("flushM", hif.flushM, e_flushM);
        chk("flushW", hif.flushW, e_flushW);
        chk("fwdAE", hif.fwdAE, e_fwdA);
        chk("fwdBE", hif.fwdBE, e_fwdB);
        chk("busy", hif.busy, e_busy);
        chk("memTimeout", hif.memTimeout, m_timeout);
        chk("stallCycles", hif.stallCycles, m_stalls);
    endtask

    task automatic settle();
        #2;
        model_eval();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        hif.rs1D = 0; hif.rs2D = 0; hif.rs1E = 0; hif.rs2E = 0;
        hif.rdE = 0; hif.rdM = 0; hif.rdW = 0;
        hif.resultSrcE = 0; hif.PCSrcE = 0; hif.mcStartE = 0;
        hif.regWriteM = 0; hif.regWriteW = 0;
        hif.memReqM = 0; hif.memReadyM = 0;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        idle();
        rst_n = 0;
        settle();
        chk("rst_stallF", hif.stallF, 0);
        chk("rst_flushD", hif.flushD, 1);
        chk("rst_flushM", hif.flushM, 1);
        tick();
        cyc();
        rst_n = 1;
        settle();
        chk("rst_busy", hif.busy, 0);
        chk("rst_cnt", hif.stallCycles, 0);
        tick();

        // forwarding: M beats W, x0 never forwards
        hif.rs1E = 5; hif.rdM = 5; hif.regWriteM = 1; hif.rdW = 5; hif.regWriteW = 1;
        settle(); chk("fwd_m", hif.fwdAE, 2'b10); tick();
        hif.rdM = 3;
        settle(); chk("fwd_w", hif.fwdAE, 2'b01); tick();
        hif.rdM = 0; hif.rdW = 0;
        settle(); chk("fwd_x0", hif.fwdAE, 2'b00); tick();
        idle();

        // load-use
        hif.resultSrcE = 1; hif.rdE = 7; hif.rs2D = 7;
        settle();
        chk("lw_stallF", hif.stallF, 1); chk("lw_stallD", hif.stallD, 1); chk("lw_flushE", hif.flushE, 1);
        tick();
        hif.rdE = 0;
        settle(); chk("lw_x0", hif.stallF, 0); tick();
        idle();

        // multi-cycle op, MC_LAT=4
        hif.mcStartE = 1;
        settle(); chk("mc0_stall", hif.stallF, 1); chk("mc0_flushM", hif.flushM, 1); chk("mc0_busy", hif.busy, 0); tick();
        hif.mcStartE = 0;
        settle(); chk("mc1_stall", hif.stallE, 1); chk("mc1_busy", hif.busy, 1); tick();
        settle(); chk("mc2_stall", hif.stallF, 1); tick();
        settle(); chk("mc3_stall", hif.stallF, 0); chk("mc3_busy", hif.busy, 1); tick();
        settle(); chk("mc4_busy", hif.busy, 0); chk("mc_cnt", hif.stallCycles, 4); tick();

`ifdef HAZARD_MEM_WAIT_EN
        hif.memReqM = 1; hif.memReadyM = 0; hif.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_stallM", hif.stallM, 1); chk("mw_flushW", hif.flushW, 1); chk("mw_flushD", hif.flushD, 0);
            tick();
        end
        hif.memReadyM = 1;
        settle(); chk("mw_rel_stall", hif.stallF, 0); chk("mw_rel_flushD", hif.flushD, 1); tick();
        idle();
        settle(); chk("mw_timeout", hif.memTimeout, 1); chk("mw_busy", hif.busy, 0); tick();
`else
        hif.memReqM = 1; hif.memReadyM = 0;
        settle(); chk("nomw_stallM", hif.stallM, 0); chk("nomw_flushW", hif.flushW, 0); chk("nomw_to", hif.memTimeout, 0); tick();
        idle();
`endif

        // memory wait starting when one multi-cycle stall cycle remains
        hif.mcStartE = 1; cyc();
        hif.mcStartE = 0; cyc();
        hif.memReqM = 1; hif.memReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (MEM_EN) chk("ov_stall", hif.stallF, 1);
            tick();
        end
        hif.memReadyM = 1;
        settle(); chk("ov_rel", hif.stallF, 0); tick();
        idle();
        settle(); chk("ov_busy", hif.busy, 0); tick();

        // reset mid multi-cycle op
        hif.mcStartE = 1; cyc();
        hif.mcStartE = 0; cyc();
        rst_n = 0;
        settle();
        chk("rmc_stallF", hif.stallF, 0); chk("rmc_flushE", hif.flushE, 1); chk("rmc_flushW", hif.flushW, MEM_EN);
        tick();
        rst_n = 1;
        settle(); chk("rmc_busy", hif.busy, 0); chk("rmc_cnt", hif.stallCycles, 0); chk("rmc_stall", hif.stallF, 0); tick();

        // saturation of the stall counter
        hif.resultSrcE = 1; hif.rdE = 9; hif.rs1D = 9;
        for (int i = 0; i < 70; i++) cyc();
        idle();
        settle(); chk("sat_cnt", hif.stallCycles, (1 << CNT_W) - 1); tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            hif.rs1D = REG_AW'($urandom_range(0, 3)); hif.rs2D = REG_AW'($urandom_range(0, 3));
            hif.rs1E = REG_AW'($urandom_range(0, 3)); hif.rs2E = REG_AW'($urandom_range(0, 3));
            hif.rdE  = REG_AW'($urandom_range(0, 3)); hif.rdM  = REG_AW'($urandom_range(0, 3));
            hif.rdW  = REG_AW'($urandom_range(0, 3));
            hif.resultSrcE = ($urandom_range(0, 3) == 0);
            hif.PCSrcE     = ($urandom_range(0, 7) == 0);
            hif.mcStartE   = ($urandom_range(0, 9) == 0);
            hif.regWriteM  = $urandom_range(0, 1) == 1;
            hif.regWriteW  = $urandom_range(0, 1) == 1;
            hif.memReqM    = ($urandom_range(0, 3) == 0);
            hif.memReadyM  = $urandom_range(0, 1) == 1;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It provides E-stage operand forwarding with an x0 guard and load-use stalling. It also adds sequential control for multi-cycle execute ops (mul/div) and data-memory wait states. It drives stall/flush enables for every pipeline register and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_AW, 5, register address width
- MC_LAT, 4, cycles a multi-cycle op occupies E; legal range ≥2
- MEM_TO, 255, wait cycles before memTimeout sets; legal range ≥1
- CNT_W, 16, stallCycles width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- rs1D, rs2D  in  REG_AW  D-stage source registers
- rs1E, rs2E, rdE  in  REG_AW  E-stage sources/destination
- resultSrcE  in  1  load in E
- PCSrcE  in  1  taken branch/jump resolved in E
- mcStartE  in  1  multi-cycle op in E
- rdM, regWriteM  in  REG_AW, 1  M-stage destination/write enable
- rdW, regWriteW  in  REG_AW, 1  W-stage destination/write enable
- memReqM, memReadyM  in  1, 1  M-stage data access / memory ready
- stallF, stallD, stallE, stallM  out  1  hold pipeline register
- flushD, flushE, flushM, flushW  out  1  insert bubble
- fwdAE, fwdBE  out  2  00 regfile, 01 W result, 10 M ALU result
- busy  out  1  FSM not in RUN
- memTimeout  out  1  sticky: memory wait exceeded MEM_TO
- stallCycles  out  CNT_W  saturating count of cycles with stallF=1

## Operation
- Forwarding (combinational, per operand):
  - 10 if regWriteM && rdM≠0 && rsE==rdM.
  - Otherwise 01 if regWriteW && rdW≠0 && rsE==rdW.
  - Otherwise 00.
  - M has priority.
- Load-use: lwHaz = resultSrcE && rdE≠0 && (rs1D==rdE || rs2D==rdE). It asserts stallF, stallD and flushE.
- Branch: PCSrcE asserts flushD and flushE.
- Memory wait: memWait = memReqM && !memReadyM.
  - Asserts stallF/D/E/M and flushW. Highest priority.
  - Suppresses flushD/flushE and lwHaz effects. A pending branch re-asserts PCSrcE after release.
- FSM states: RUN, MC_BUSY, MEM_WAIT.
  - RUN→MC_BUSY: on mcStartE && !memWait. Load mcCnt=MC_LAT-2. stallF/D/E and flushM are asserted in that cycle.
  - MC_BUSY: stallF/D/E and flushM are asserted while mcCnt≠0 or memWait. mcCnt decrements each cycle until 0, including during memWait. When mcCnt==0 && !memWait, stalls drop and the next state is RUN. mcStartE is ignored in MC_BUSY.
  - RUN→MEM_WAIT: on memWait. MEM_WAIT→RUN: on memReadyM. A memWait arising inside MC_BUSY stays in MC_BUSY.
- Wait counter:
  - Increments each memWait cycle and clears on any cycle without memWait.
  - memTimeout sets when the counter reaches MEM_TO and stays set until reset.
- stallCycles: increments when stallF=1 and saturates at 2^CNT_W-1.
- busy = (state≠RUN).

## Timing
- Forwarding, load-use, branch flush, and the memWait stall/flush are combinational, asserted in the same cycle as their cause.
- A multi-cycle op occupies E for exactly MC_LAT cycles (MC_LAT-1 stall cycles) when no memWait occurs.
- A load-use hazard costs 1 bubble.
- Reset: rst_n low at a rising edge gives state=RUN, mcCnt=0, wait counter=0, memTimeout=0, stallCycles=0.
- While rst_n is low:
  - all stall*=0;
  - flushD/E/M/W=1;
  - fwdAE/fwdBE=00.
- Reset mid-MC_BUSY or mid-MEM_WAIT aborts to RUN with no residual stall on the first cycle after rst_n rises.
- Simultaneous mcStartE and PCSrcE cannot occur (decoder guarantee). If it does, mcStartE wins and the flushes are suppressed.

## Configuration
- HAZARD_MEM_WAIT_EN defined: memory wait logic, MEM_WAIT state, wait counter and memTimeout are present.
- Not defined:
  - memReqM/memReadyM are ignored;
  - stallM=0 and flushW=0 always;
  - memTimeout=0;
  - MEM_WAIT is unreachable.
  - Forwarding, load-use and multi-cycle behaviour are unchanged.

## Test plan
- Forwarding: rs1E=5, rdM=5, regWriteM=1, rdW=5, regWriteW=1 → fwdAE=10. Same with rdM=rdW=0 → fwdAE=00.
- Load-use: resultSrcE=1, rdE=7, rs2D=7 → stallF=stallD=flushE=1 for 1 cycle. With rdE=0 → no stall.
- Multi-cycle, MC_LAT=4: mcStartE pulse in RUN → stallF/D/E=1 and flushM=1 for 3 cycles, busy=1 for cycles 1–3, then RUN; stallCycles increases by 3.
- Memory wait (macro on): memReqM=1, memReadyM=0 for 3 cycles then 1 → stallF..M and flushW=1 for 3 cycles, PCSrcE flush suppressed. With MEM_TO=2 → memTimeout=1 and sticky.
- Overlap: memWait begins while MC_BUSY mcCnt=1 and lasts 4 cycles → release exactly when memReadyM=1; mcCnt holds 0.
- Reset: assert rst_n=0 during MC_BUSY → flushD/E/M/W=1, all stalls 0. On the next cycle, busy=0 and stallCycles=0.
